// File: rtl/montgomery_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : montgomery_arbiter
// Description : Shares one Montgomery multiplier core between two requesters.
//               Holds the modulus configuration (n, s, k), accepts operand
//               pairs from two valid/ready ports with round-robin arbitration,
//               launches the core, supervises completion with a timeout and
//               returns the result tagged with the owning requester id.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               cfg_we/cfg_n/s/k      - configuration write (IDLE only)
//               reqX_valid/a/b/ready  - requester 0/1 operand ports
//               rsp_valid/ready/id/c/err - tagged result port
//               mm_start/a/b/n/s/k    - registered core launch interface
//               mm_c/mm_done          - core result and completion strobe
//               busy                  - an operation is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module montgomery_arbiter #(
    parameter int WIDTH   = 256,
    parameter int KW      = 8,
    parameter int TIMEOUT = 4096,
    parameter int TW      = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_n,
    input  logic [WIDTH-1:0] cfg_s,
    input  logic [KW-1:0]    cfg_k,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_c,
    output logic             rsp_err,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_n,
    output logic [WIDTH-1:0] mm_s,
    output logic [KW-1:0]    mm_k,
    input  logic [WIDTH-1:0] mm_c,
    input  logic             mm_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // The counter holds the number of BUSY cycles already elapsed. The last
    // permitted BUSY cycle is the one where the counter is about to reach
    // TIMEOUT-1, so the response appears TIMEOUT cycles after the start strobe.
    localparam logic [TW-1:0] c_busy_last = TW'(TIMEOUT - 2);

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic             mm_start_q, mm_start_d;
    logic [WIDTH-1:0] mm_a_q, mm_a_d;
    logic [WIDTH-1:0] mm_b_q, mm_b_d;
    logic [WIDTH-1:0] mm_n_q, mm_n_d;
    logic [WIDTH-1:0] mm_s_q, mm_s_d;
    logic [KW-1:0]    mm_k_q, mm_k_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
    logic             rsp_err_q, rsp_err_d;

    logic             w_grant_any;
    logic             w_grant_id;

    // Grant is only possible in IDLE and a config write takes that cycle.
    // With a single valid requester it wins outright; on contention rr picks.
    assign w_grant_any = (state_q == S_IDLE) && !cfg_we && (req0_valid || req1_valid);
    assign w_grant_id  = (req0_valid && req1_valid) ? rr_q : req1_valid;

    assign req0_ready = w_grant_any && !w_grant_id;
    assign req1_ready = w_grant_any &&  w_grant_id;

    assign mm_start  = mm_start_q;
    assign mm_a      = mm_a_q;
    assign mm_b      = mm_b_q;
    assign mm_n      = mm_n_q;
    assign mm_s      = mm_s_q;
    assign mm_k      = mm_k_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        mm_start_d  = 1'b0;
        mm_a_d      = mm_a_q;
        mm_b_d      = mm_b_q;
        mm_n_d      = mm_n_q;
        mm_s_d      = mm_s_q;
        mm_k_d      = mm_k_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_c_d     = rsp_c_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    mm_n_d = cfg_n;
                    mm_s_d = cfg_s;
                    mm_k_d = cfg_k;
                end else if (w_grant_any) begin
                    mm_a_d     = w_grant_id ? req1_a : req0_a;
                    mm_b_d     = w_grant_id ? req1_b : req0_b;
                    rsp_id_d   = w_grant_id;
                    rr_d       = ~w_grant_id;
                    mm_start_d = 1'b1;  // registered: high during LAUNCH only
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                cnt_d = cnt_q + TW'(1);
                // Completion takes precedence over a coincident timeout.
                if (mm_done) begin
                    rsp_c_d     = mm_c;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (cnt_q == c_busy_last) begin
                    rsp_c_d     = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_q        <= 1'b0;
            cnt_q       <= '0;
            mm_start_q  <= 1'b0;
            mm_a_q      <= '0;
            mm_b_q      <= '0;
            mm_n_q      <= '0;
            mm_s_q      <= '0;
            mm_k_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_c_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            mm_start_q  <= mm_start_d;
            mm_a_q      <= mm_a_d;
            mm_b_q      <= mm_b_d;
            mm_n_q      <= mm_n_d;
            mm_s_q      <= mm_s_d;
            mm_k_q      <= mm_k_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_c_q     <= rsp_c_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
`default_nettype wire
